// File: rtl/if_pkg.sv
// ---------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch stage.
//   XLEN        : datapath width that the fetch packet type is built from
//   NOP_INSTR   : instruction shown to IF/ID when no real instruction exists
//   PC_STEP     : sequential fetch increment (one 32-bit instruction)
//   fetch_pkt_t : {instr, pc} pair as handed to the IF/ID register
//   word_align  : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package if_pkg;

    localparam int unsigned     XLEN      = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_pkt_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_hold_reg.sv
// ---------------------------------------------------------------------------
// fetch_hold_reg
// One-entry capture/hold register for a fetch response that arrives while
// the IF/ID register is stalled.
//   clk     in  : clock
//   reset   in  : synchronous, active-high; empties the entry
//   clear   in  : empties the entry (consumed by IF/ID or squashed)
//   capture in  : loads din and marks the entry valid
//   din     in  : fetch packet to capture
//   valid   out : entry holds a live packet
//   dout    out : held packet
// ---------------------------------------------------------------------------
module fetch_hold_reg
    import if_pkg::fetch_pkt_t;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       capture,
    input  fetch_pkt_t din,
    output logic       valid,
    output fetch_pkt_t dout
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
        end
    end

    // NOTE: the payload is deliberately left out of reset; valid alone
    // qualifies it, so resetting the data would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (capture) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch stage feeding the IF/ID pipeline register. Owns the
// fetch PC, issues requests to a synchronous-read instruction memory
// (response one cycle after the request), parks a response that arrives
// during a stall in a one-entry hold register, and applies redirects from EX.
//   clk          in  : clock
//   reset        in  : synchronous, active-high
//   Reg_Stall    in  : IF/ID is frozen; present a stable output
//   Redirect     in  : taken branch/jump from EX (wins over Reg_Stall)
//   Redirect_PC  in  : redirect target, low two bits ignored
//   imem_req     out : fetch request this cycle
//   imem_addr    out : word-aligned fetch address
//   imem_rdata   in  : instruction for the previous cycle's request
//   Instr        out : instruction to IF/ID (NOP_INSTR when invalid)
//   PC           out : PC of Instr (0 when invalid)
//   Instr_Valid  out : Instr/PC carry a real fetched instruction
//   IF_Flush     out : clears IF/ID this cycle (combinational from Redirect)
// WIDTH must equal if_pkg::XLEN, which sizes the fetch packet type.
// ---------------------------------------------------------------------------
module if_fetch_unit
    import if_pkg::XLEN;
    import if_pkg::PC_STEP;
    import if_pkg::fetch_pkt_t;
    import if_pkg::word_align;
#(
    parameter int unsigned      WIDTH     = XLEN,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter logic [WIDTH-1:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Reg_Stall,
    input  logic             Redirect,
    input  logic [WIDTH-1:0] Redirect_PC,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] Instr,
    output logic [WIDTH-1:0] PC,
    output logic             Instr_Valid,
    output logic             IF_Flush
);

    logic [WIDTH-1:0] fetch_pc;     // next sequential fetch address
    logic             inflight_v;   // a request was issued last cycle
    logic [WIDTH-1:0] inflight_pc;  // address of that request
    logic             hold_v;
    fetch_pkt_t       hold_pkt;
    fetch_pkt_t       resp_pkt;     // memory response paired with its PC
    logic [WIDTH-1:0] redirect_tgt;
    logic             hold_clear;
    logic             hold_capture;

    assign redirect_tgt = word_align(Redirect_PC);
    assign resp_pkt     = '{instr: imem_rdata, pc: inflight_pc};

    // Request and flush control. Priority: reset > Redirect > Reg_Stall > normal.
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        imem_req     = 1'b0;
        imem_addr    = fetch_pc;
        IF_Flush     = 1'b0;
        hold_clear   = 1'b0;
        hold_capture = 1'b0;
        if (!reset) begin
            if (Redirect) begin
                imem_req   = 1'b1;
                imem_addr  = redirect_tgt;
                IF_Flush   = 1'b1;
                hold_clear = 1'b1;
            end else if (Reg_Stall) begin
                // Only the first stall cycle has a fresh response to park;
                // later stall cycles keep showing the parked copy.
                hold_capture = inflight_v && !hold_v;
            end else begin
                imem_req   = 1'b1;
                hold_clear = 1'b1;  // IF/ID takes the held packet this cycle
            end
        end
    end

    // Output mux: a parked packet is always older than anything in flight.
    always_comb begin
        Instr       = NOP_INSTR;
        PC          = '0;
        Instr_Valid = 1'b0;
        if (!reset && !Redirect) begin
            if (hold_v) begin
                Instr       = hold_pkt.instr;
                PC          = hold_pkt.pc;
                Instr_Valid = 1'b1;
            end else if (inflight_v) begin
                Instr       = resp_pkt.instr;
                PC          = resp_pkt.pc;
                Instr_Valid = 1'b1;
            end
        end
    end

    // PC register and in-flight tracking; fetch_pc + PC_STEP wraps naturally.
    // NOTE: state registers use non-blocking assignments so every flop sees
    // the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= word_align(RESET_PC);
            inflight_v  <= 1'b0;
            inflight_pc <= '0;
        end else if (Redirect) begin
            fetch_pc    <= redirect_tgt + PC_STEP;
            inflight_v  <= 1'b1;
            inflight_pc <= redirect_tgt;
        end else if (Reg_Stall) begin
            inflight_v  <= 1'b0;
        end else begin
            fetch_pc    <= fetch_pc + PC_STEP;
            inflight_v  <= 1'b1;
            inflight_pc <= fetch_pc;
        end
    end

    fetch_hold_reg u_hold (
        .clk     (clk),
        .reset   (reset),
        .clear   (hold_clear),
        .capture (hold_capture),
        .din     (resp_pkt),
        .valid   (hold_v),
        .dout    (hold_pkt)
    );

    // At most one outstanding response exists at any time.
    hold_inflight_exclusive: assert property (
        @(posedge clk) disable iff (reset) !(hold_v && inflight_v)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Stimulus drives one cycle at a time and, from a transaction-level model
// (a queue of requested-but-not-yet-consumed fetch addresses), pushes the
// expected per-cycle response into a scoreboard queue. An independent
// monitor pops one entry per cycle on the falling edge and compares.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        Reg_Stall;
    logic        Redirect;
    logic [31:0] Redirect_PC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic        Instr_Valid;
    logic        IF_Flush;

    typedef struct {
        bit          req;
        logic [31:0] addr;
        bit          flush;
        bit          valid;
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];    // scoreboard: one expectation per cycle
    logic [31:0] pend_q[$];   // model: requested, not yet taken by IF/ID
    logic [31:0] next_pc;     // model: next sequential fetch address

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .WIDTH     (32),
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Reg_Stall   (Reg_Stall),
        .Redirect    (Redirect),
        .Redirect_PC (Redirect_PC),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .Instr       (Instr),
        .PC          (PC),
        .Instr_Valid (Instr_Valid),
        .IF_Flush    (IF_Flush)
    );

    // Instruction memory contents are a fixed function of the address.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h0137_0000;
    endfunction

    // Synchronous-read memory: data for a request appears the next cycle.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_word(imem_addr);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, want);
        end
    endtask

    // One clock cycle of stimulus plus the model's expectation for it.
    task automatic step(input bit rst, input bit stall, input bit redir, input logic [31:0] rpc);
        exp_t        e;
        logic [31:0] tgt;
        @(posedge clk);
        #1;
        reset       = rst;
        Reg_Stall   = stall;
        Redirect    = redir;
        Redirect_PC = rpc;
        tgt         = {rpc[31:2], 2'b00};
        e.req   = 1'b0;
        e.addr  = '0;
        e.flush = 1'b0;
        e.valid = 1'b0;
        e.instr = NOP;
        e.pc    = '0;
        if (rst) begin
            pend_q.delete();
            next_pc = RESET_PC;
        end else begin
            e.valid = !redir && (pend_q.size() > 0);
            if (e.valid) begin
                e.pc    = pend_q[0];
                e.instr = imem_word(pend_q[0]);
            end
            e.flush = redir;
            e.req   = redir || !stall;
            e.addr  = redir ? tgt : next_pc;
            if (redir) begin
                pend_q.delete();
                pend_q.push_back(tgt);
                next_pc = tgt + 32'd4;
            end else if (!stall) begin
                if (pend_q.size() > 0) void'(pend_q.pop_front());
                pend_q.push_back(next_pc);
                next_pc = next_pc + 32'd4;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic run_normal(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic run_stall(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    // Monitor: compares whatever the DUT presents against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("imem_req",    32'(imem_req),    32'(e.req));
                if (e.req) check("imem_addr", imem_addr, e.addr);
                check("IF_Flush",    32'(IF_Flush),    32'(e.flush));
                check("Instr_Valid", 32'(Instr_Valid), 32'(e.valid));
                check("PC",          PC,               e.pc);
                check("Instr",       Instr,            e.instr);
            end
        end
    end

    initial begin
        bit          r_rst, r_stall, r_redir;
        logic [31:0] r_pc;
        reset       = 1'b1;
        Reg_Stall   = 1'b0;
        Redirect    = 1'b0;
        Redirect_PC = '0;
        next_pc     = RESET_PC;

        // Reset release and sequential stream 0,4,8,...
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        run_normal(3);
        // Three-cycle stall with PC=8 in flight, then release.
        run_stall(3);
        run_normal(3);
        // Redirect to 0x100 while PC=0x20 is in flight.
        while (next_pc != 32'h24) run_normal(1);
        step(1'b0, 1'b0, 1'b1, 32'h100);
        run_normal(3);
        // Redirect together with stall while a packet is parked.
        run_stall(2);
        step(1'b0, 1'b1, 1'b1, 32'h200);
        run_stall(2);
        run_normal(3);
        // Address wrap and unaligned redirect target.
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
        run_normal(3);
        step(1'b0, 1'b0, 1'b1, 32'h103);
        run_normal(2);
        // Reset during a stall with a parked packet.
        run_normal(2);
        run_stall(2);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        run_normal(3);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r_rst   = ($urandom_range(63) == 0);
            r_stall = ($urandom_range(3) == 0);
            r_redir = ($urandom_range(7) == 0);
            r_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(31)))
                                               : $urandom;
            step(r_rst, r_stall, r_redir, r_pc);
        end
        run_normal(2);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
